// File: rtl/d5m_pattern_source.sv
// Synthetic D5M pixel bus: FVAL/LVAL framing with 12-bit raw test patterns, one pixel per clock.
// Optional macro D5M_SRC_NOISE_EN XORs LFSR noise into oDATA[2:0]; timing is identical either way.
module d5m_pattern_source #(
   parameter int H_ACTIVE = 1280,
   parameter int H_BLANK  = 64,
   parameter int V_ACTIVE = 960,
   parameter int V_BLANK  = 16
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iENABLE,
   input  logic [1:0]  iPATTERN,
   output logic [11:0] oDATA,
   output logic        oLVAL,
   output logic        oFVAL,
   output logic [15:0] oFrame_Cont,
   output logic [2:0]  o_state
);

   localparam int VBLK_LEN = V_BLANK * (H_ACTIVE + H_BLANK);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_LINE, S_HBLK, S_VBLK} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_cnt;
   logic [11:0] r_y;
   logic [1:0]  r_pat;
   logic [11:0] r_data;
   logic        r_lval, r_fval;
   logic [15:0] r_frame_cnt;
   logic [11:0] w_x, w_pat, w_pix;
   logic        w_last;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_last = 1'b0;
      case (r_state)
         S_IDLE: if (iENABLE) w_next = S_PRE;
         S_PRE: begin
            w_last = (r_cnt == 32'(H_BLANK - 1));
            if (w_last) w_next = S_LINE;
         end
         S_LINE: begin
            w_last = (r_cnt == 32'(H_ACTIVE - 1));
            if (w_last) w_next = S_HBLK;
         end
         S_HBLK: begin
            w_last = (r_cnt == 32'(H_BLANK - 1));
            if (w_last) w_next = (r_y == 12'(V_ACTIVE - 1)) ? S_VBLK : S_LINE;
         end
         S_VBLK: begin
            // Run request is only honoured here and in IDLE, so frames are never truncated.
            w_last = (r_cnt == 32'(VBLK_LEN - 1));
            if (w_last) w_next = iENABLE ? S_PRE : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // r_cnt is the position inside the current state; in LINE it is the pixel x.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_cnt <= '0;
         r_y   <= '0;
         r_pat <= '0;
      end else begin
         if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
         else                                        r_cnt <= r_cnt + 32'd1;
         if (w_next == S_PRE && r_state != S_PRE) begin
            r_pat <= iPATTERN;
            r_y   <= '0;
         end else if (r_state == S_HBLK && w_next == S_LINE) begin
            r_y <= r_y + 12'd1;
         end
      end
   end

   assign w_x = r_cnt[11:0];

   always_comb begin
      w_pat = 12'h000;
      case (r_pat)
         2'd0: w_pat = w_x;
         2'd1: w_pat = r_y;
         2'd2: w_pat = (w_x[4] ^ r_y[4]) ? 12'hFFF : 12'h000;
         default: begin
            // D5M Bayer order: even rows G R, odd rows B G.
            case ({r_y[0], w_x[0]})
               2'b00:   w_pat = 12'h800;
               2'b01:   w_pat = 12'hFFF;
               2'b10:   w_pat = 12'h000;
               default: w_pat = 12'h800;
            endcase
         end
      endcase
   end

`ifdef D5M_SRC_NOISE_EN
   logic [11:0] r_lfsr;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)                   r_lfsr <= 12'hACE;
      else if (r_state == S_LINE) r_lfsr <= {r_lfsr[10:0], r_lfsr[11] ^ r_lfsr[5] ^ r_lfsr[3] ^ r_lfsr[0]};
   end

   assign w_pix = {w_pat[11:3], w_pat[2:0] ^ r_lfsr[2:0]};
`else
   assign w_pix = w_pat;
`endif

   // Outputs lag the state by one clock, which keeps every phase length exact.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_data      <= '0;
         r_lval      <= 1'b0;
         r_fval      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_lval <= (r_state == S_LINE);
         r_fval <= (r_state == S_PRE) || (r_state == S_LINE) || (r_state == S_HBLK);
         r_data <= (r_state == S_LINE) ? w_pix : 12'h000;
         if (r_fval && r_state == S_VBLK) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign oDATA       = r_data;
   assign oLVAL       = r_lval;
   assign oFVAL       = r_fval;
   assign oFrame_Cont = r_frame_cnt;
   assign o_state     = r_state;

endmodule

// File: tb/tb_d5m_pattern_source.sv
// Bench for d5m_pattern_source: frame-position reference model, per-cycle compare, directed literal checks.
module tb_d5m_pattern_source;

   localparam int HA  = 8;
   localparam int HB  = 4;
   localparam int VA  = 4;
   localparam int VB  = 2;
   localparam int LP  = HA + HB;
   localparam int FVH = VA * LP + HB;
   localparam int VBL = VB * LP;
   localparam int P   = FVH + VBL;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iENABLE = 1'b0;
   logic [1:0]  iPATTERN = 2'd0;
   logic [11:0] oDATA;
   logic        oLVAL, oFVAL;
   logic [15:0] oFrame_Cont;
   logic [2:0]  o_state;

   d5m_pattern_source #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
      .iCLK(iCLK), .iRST(iRST), .iENABLE(iENABLE), .iPATTERN(iPATTERN),
      .oDATA(oDATA), .oLVAL(oLVAL), .oFVAL(oFVAL), .oFrame_Cont(oFrame_Cont), .o_state(o_state)
   );

   always #5 iCLK = ~iCLK;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] pat_val(input int p, input int x, input int y);
      logic [11:0] xv, yv;
      xv = 12'(x);
      yv = 12'(y);
      case (p)
         0: return xv;
         1: return yv;
         2: return (xv[4] ^ yv[4]) ? 12'hFFF : 12'h000;
         default: begin
            if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
            else            return (x % 2 == 0) ? 12'h000 : 12'h800;
         end
      endcase
   endfunction

   // Reference model: tracks which clock of the frame period the outputs show.
   logic [29:0] exp_q[$];
   bit          m_idle = 1'b1;
   int          m_pos = 0;
   int          m_pat = 0;
   logic [15:0] m_fcnt = '0;
   int          m_q, m_x, m_ln;
   logic        m_f, m_l;
   logic [11:0] m_d;

   always @(posedge iCLK) begin
      m_f = 1'b0; m_l = 1'b0; m_d = 12'h000;
      if (iRST) begin
         m_idle = 1'b1; m_pos = 0; m_pat = 0; m_fcnt = '0;
         exp_q.delete();
      end else if (m_idle) begin
         if (iENABLE) begin
            m_idle = 1'b0; m_pos = -1; m_pat = int'(iPATTERN);
         end
      end else begin
         m_pos = m_pos + 1;
         if (m_pos < FVH) begin
            m_f = 1'b1;
            m_q = m_pos - HB;
            if (m_q >= 0) begin
               m_ln = m_q / LP;
               m_x  = m_q % LP;
               if (m_x < HA) begin
                  m_l = 1'b1;
                  m_d = pat_val(m_pat, m_x, m_ln);
               end
            end
         end
         if (m_pos == FVH) m_fcnt = m_fcnt + 16'd1;
         if (m_pos == P - 1) begin
            if (iENABLE) begin
               m_pos = -1; m_pat = int'(iPATTERN);
            end else begin
               m_idle = 1'b1;
            end
         end
      end
      exp_q.push_back({m_fcnt, m_f, m_l, m_d});
   end

   logic [29:0] c_e;
   always @(negedge iCLK) begin
      if (exp_q.size() > 0) begin
         c_e = exp_q.pop_front();
         check("data", 32'(oDATA), 32'(c_e[11:0]));
         check("lval", 32'(oLVAL), 32'(c_e[12]));
         check("fval", 32'(oFVAL), 32'(c_e[13]));
         check("frame_cnt", 32'(oFrame_Cont), 32'(c_e[29:14]));
      end
   end

   // Monitor: FVAL run lengths and the pixel grid of the latest frame.
   int          hi_len = 0, lo_len = 0, last_hi = 0, last_lo = 0;
   int          falls = 0, rises = 0, cy = 0, cx = 0;
   logic        prev_f = 1'b0, prev_l = 1'b0;
   logic [11:0] cap[VA][HA];

   always @(negedge iCLK) begin
      if (oFVAL && !prev_f) begin
         rises++; last_lo = lo_len; hi_len = 1; cy = 0; cx = 0;
      end else if (oFVAL) hi_len++;
      if (!oFVAL && prev_f) begin
         falls++; last_hi = hi_len; lo_len = 1;
      end else if (!oFVAL) lo_len++;
      if (oLVAL) begin
         if (cy < VA && cx < HA) cap[cy][cx] = oDATA;
         cx++;
      end else if (prev_l) begin
         cy++; cx = 0;
      end
      prev_f = oFVAL;
      prev_l = oLVAL;
   end

   task automatic wait_falls(input int target);
      int n = 0;
      while (falls < target && n < 400) begin
         @(negedge iCLK); #1; n++;
      end
      check("wait_fval_fall", 32'(falls), 32'(target));
   endtask

   task automatic wait_rises(input int target);
      int n = 0;
      while (rises < target && n < 400) begin
         @(negedge iCLK); #1; n++;
      end
      check("wait_fval_rise", 32'(rises), 32'(target));
   endtask

   task automatic wait_line2();
      int n = 0;
      while (!(cy == 2 && oLVAL === 1'b1) && n < 400) begin
         @(negedge iCLK); #1; n++;
      end
      check("reach_line2", 32'(cy == 2 && oLVAL === 1'b1), 32'd1);
   endtask

   int f0;
   int n0;

   initial begin
      repeat (3) @(negedge iCLK);
      #1;
      check("rst_fval", 32'(oFVAL), 32'd0);
      check("rst_lval", 32'(oLVAL), 32'd0);
      check("rst_data", 32'(oDATA), 32'd0);
      check("rst_fcnt", 32'(oFrame_Cont), 32'd0);
      iRST = 1'b0; iENABLE = 1'b1; iPATTERN = 2'd0;

      // FVAL rises on the second edge after enable.
      @(posedge iCLK); #1;
      check("fval_edge1", 32'(oFVAL), 32'd0);
      @(posedge iCLK); #1;
      check("fval_edge2", 32'(oFVAL), 32'd1);

      // Pattern change mid-frame only takes effect next frame.
      wait_line2();
      iPATTERN = 2'd1;
      wait_falls(1);
      check("fval_high_len", 32'(last_hi), 32'd52);
      check("fcnt_1", 32'(oFrame_Cont), 32'd1);
      check("ramp_l0_x0", 32'(cap[0][0]), 32'h0);
      check("ramp_l0_x7", 32'(cap[0][7]), 32'h7);
      check("ramp_l3_x5", 32'(cap[3][5]), 32'h5);
      wait_rises(2);
      check("vblk_len", 32'(last_lo), 32'd24);
      iPATTERN = 2'd3;
      wait_falls(2);
      check("vramp_l1", 32'(cap[1][3]), 32'h1);
      check("vramp_l2", 32'(cap[2][0]), 32'h2);
      check("vramp_l3", 32'(cap[3][7]), 32'h3);

      wait_falls(3);
      check("bayer_l0_x0", 32'(cap[0][0]), 32'h800);
      check("bayer_l0_x1", 32'(cap[0][1]), 32'hFFF);
      check("bayer_l1_x0", 32'(cap[1][0]), 32'h000);
      check("bayer_l1_x1", 32'(cap[1][1]), 32'h800);
      check("bayer_l2_x2", 32'(cap[2][2]), 32'h800);
      check("fcnt_3", 32'(oFrame_Cont), 32'd3);

      // Drop enable during line 2: frame completes, then idle.
      iPATTERN = 2'd2;
      wait_rises(4);
      wait_line2();
      iENABLE = 1'b0;
      wait_falls(4);
      check("trunc_high_len", 32'(last_hi), 32'd52);
      repeat (80) begin @(negedge iCLK); #1; end
      check("idle_no_rise", 32'(rises), 32'd4);
      check("idle_fval", 32'(oFVAL), 32'd0);

      // Randomised run: enable toggles and pattern changes at arbitrary times.
      iENABLE = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge iCLK); #1;
         if ($urandom_range(0, 99) < 2) iENABLE = ~iENABLE;
         if ($urandom_range(0, 9) == 0) iPATTERN = 2'($urandom_range(0, 3));
      end

      // Asynchronous reset during an active line.
      iENABLE = 1'b1;
      n0 = 0;
      while (oLVAL !== 1'b1 && n0 < 400) begin
         @(negedge iCLK); #1; n0++;
      end
      check("reach_lval", 32'(oLVAL), 32'd1);
      iRST = 1'b1;
      #1;
      check("arst_lval", 32'(oLVAL), 32'd0);
      check("arst_fval", 32'(oFVAL), 32'd0);
      check("arst_data", 32'(oDATA), 32'd0);
      check("arst_fcnt", 32'(oFrame_Cont), 32'd0);
      @(negedge iCLK); #1;
      iRST = 1'b0; iENABLE = 1'b0;
      repeat (3) begin @(negedge iCLK); #1; end

      // Frame counter wrap.
      force dut.r_frame_cnt = 16'hFFFF;
      m_fcnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      @(negedge iCLK); #1;
      iENABLE = 1'b1;
      f0 = falls;
      wait_falls(f0 + 1);
      check("fcnt_wrap", 32'(oFrame_Cont), 32'd0);
      iENABLE = 1'b0;
      repeat (100) begin @(negedge iCLK); #1; end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
